// File: rtl/axil_wr_router.sv
// Write-path router: steers AW/W to the decoded slave, returns its B, and answers unmapped writes with DECERR.
// Slave valid 2 cycles after master AW&W valid (DECERR bvalid after 3); all flow is valid/ready, master stalls until the selected slave accepts.
module axil_wr_router #(
  parameter int NUMBER_SLAVE   = 4,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic [NUMBER_SLAVE-1:0]       slv_valid,
  input  logic                          slv_invalid,
  input  logic [AXI_ADDR_WIDTH-1:0]     m_axil_awaddr,
  input  logic                          m_axil_awvalid,
  output logic                          m_axil_awready,
  input  logic [AXI_DATA_WIDTH-1:0]     m_axil_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0]   m_axil_wstrb,
  input  logic                          m_axil_wvalid,
  output logic                          m_axil_wready,
  output logic [1:0]                    m_axil_bresp,
  output logic                          m_axil_bvalid,
  input  logic                          m_axil_bready,
  output logic [AXI_ADDR_WIDTH-1:0]     s_axil_awaddr,
  output logic [NUMBER_SLAVE-1:0]       s_axil_awvalid,
  input  logic [NUMBER_SLAVE-1:0]       s_axil_awready,
  output logic [AXI_DATA_WIDTH-1:0]     s_axil_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0]   s_axil_wstrb,
  output logic [NUMBER_SLAVE-1:0]       s_axil_wvalid,
  input  logic [NUMBER_SLAVE-1:0]       s_axil_wready,
  input  logic [2*NUMBER_SLAVE-1:0]     s_axil_bresp,
  input  logic [NUMBER_SLAVE-1:0]       s_axil_bvalid,
  output logic [NUMBER_SLAVE-1:0]       s_axil_bready
);

  typedef enum logic [2:0] {IDLE, DECODE, FWD, RESP, ERR_ACK, ERR_RESP} state_t;

  state_t                  r_state, w_state_nxt;
  logic [NUMBER_SLAVE-1:0] r_sel, w_sel_nxt, w_sel_low;
  logic                    r_aw_done, r_w_done, w_aw_done_nxt, w_w_done_nxt;
  logic                    w_sel_awready, w_sel_wready, w_sel_bvalid;
  logic [1:0]              w_sel_bresp;
  logic                    w_fwd_awready, w_fwd_wready, w_aw_hs, w_w_hs;

  assign s_axil_awaddr = m_axil_awaddr;
  assign s_axil_wdata  = m_axil_wdata;
  assign s_axil_wstrb  = m_axil_wstrb;

  // Isolate the lowest set bit so a malformed multi-hot select still picks one slave.
  assign w_sel_low = slv_valid & (~slv_valid + NUMBER_SLAVE'(1));

  always_comb begin
    w_sel_awready = 1'b0;
    w_sel_wready  = 1'b0;
    w_sel_bvalid  = 1'b0;
    w_sel_bresp   = 2'b00;
    for (int i = 0; i < NUMBER_SLAVE; i++) begin
      if (r_sel[i]) begin
        w_sel_awready = s_axil_awready[i];
        w_sel_wready  = s_axil_wready[i];
        w_sel_bvalid  = s_axil_bvalid[i];
        w_sel_bresp   = s_axil_bresp[2*i +: 2];
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state   <= IDLE;
      r_sel     <= '0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_sel     <= w_sel_nxt;
      r_aw_done <= w_aw_done_nxt;
      r_w_done  <= w_w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_sel_nxt      = r_sel;
    w_aw_done_nxt  = r_aw_done;
    w_w_done_nxt   = r_w_done;
    w_fwd_awready  = w_sel_awready & ~r_aw_done;
    w_fwd_wready   = w_sel_wready & ~r_w_done;
    w_aw_hs        = 1'b0;
    w_w_hs         = 1'b0;
    m_axil_awready = 1'b0;
    m_axil_wready  = 1'b0;
    m_axil_bvalid  = 1'b0;
    m_axil_bresp   = 2'b00;
    s_axil_awvalid = '0;
    s_axil_wvalid  = '0;
    s_axil_bready  = '0;
    case (r_state)
      IDLE: begin
        if (m_axil_awvalid && m_axil_wvalid) w_state_nxt = DECODE;
      end
      DECODE: begin
        w_sel_nxt = w_sel_low;
        if (|slv_valid)       w_state_nxt = FWD;
        else if (slv_invalid) w_state_nxt = ERR_ACK;
        else                  w_state_nxt = IDLE;
      end
      FWD: begin
        s_axil_awvalid = r_sel & {NUMBER_SLAVE{m_axil_awvalid & ~r_aw_done}};
        s_axil_wvalid  = r_sel & {NUMBER_SLAVE{m_axil_wvalid & ~r_w_done}};
        m_axil_awready = w_fwd_awready;
        m_axil_wready  = w_fwd_wready;
        w_aw_hs        = m_axil_awvalid & w_fwd_awready;
        w_w_hs         = m_axil_wvalid & w_fwd_wready;
        w_aw_done_nxt  = r_aw_done | w_aw_hs;
        w_w_done_nxt   = r_w_done | w_w_hs;
        if ((r_aw_done | w_aw_hs) && (r_w_done | w_w_hs)) begin
          w_aw_done_nxt = 1'b0;
          w_w_done_nxt  = 1'b0;
          w_state_nxt   = RESP;
        end
      end
      RESP: begin
        m_axil_bvalid = w_sel_bvalid;
        m_axil_bresp  = w_sel_bresp;
        s_axil_bready = r_sel & {NUMBER_SLAVE{m_axil_bready}};
        if (w_sel_bvalid && m_axil_bready) w_state_nxt = IDLE;
      end
      ERR_ACK: begin
        m_axil_awready = 1'b1;
        m_axil_wready  = 1'b1;
        w_state_nxt    = ERR_RESP;
      end
      ERR_RESP: begin
        m_axil_bvalid = 1'b1;
        m_axil_bresp  = 2'b11;
        if (m_axil_bready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_axil_wr_router.sv
// Scoreboard bench for axil_wr_router: directed writes push expected route/response, a monitor pops and compares.
module tb_axil_wr_router;
  localparam int NS = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW/8;

  logic             aclk = 1'b0;
  logic             aresetn;
  logic [NS-1:0]    slv_valid;
  logic             slv_invalid;
  logic [AW-1:0]    m_axil_awaddr;
  logic             m_axil_awvalid, m_axil_awready;
  logic [DW-1:0]    m_axil_wdata;
  logic [SW-1:0]    m_axil_wstrb;
  logic             m_axil_wvalid, m_axil_wready;
  logic [1:0]       m_axil_bresp;
  logic             m_axil_bvalid, m_axil_bready;
  logic [AW-1:0]    s_axil_awaddr;
  logic [NS-1:0]    s_axil_awvalid, s_axil_awready;
  logic [DW-1:0]    s_axil_wdata;
  logic [SW-1:0]    s_axil_wstrb;
  logic [NS-1:0]    s_axil_wvalid, s_axil_wready;
  logic [2*NS-1:0]  s_axil_bresp;
  logic [NS-1:0]    s_axil_bvalid, s_axil_bready;

  int n_checks = 0;
  int n_fail   = 0;
  logic [NS-1:0] exp_route_q[$];
  logic [1:0]    exp_resp_q[$];

  // slave behaviour knobs
  int       aw_lat[NS];
  int       w_lat[NS];
  logic [1:0] resp_cfg[NS];
  int       aw_cnt[NS];
  int       w_cnt[NS];
  logic     got_aw[NS];
  logic     got_w[NS];

  always #5 aclk = ~aclk;

  axil_wr_router #(.NUMBER_SLAVE(NS), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW)) dut (
    .aclk(aclk), .aresetn(aresetn), .slv_valid(slv_valid), .slv_invalid(slv_invalid),
    .m_axil_awaddr(m_axil_awaddr), .m_axil_awvalid(m_axil_awvalid), .m_axil_awready(m_axil_awready),
    .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb), .m_axil_wvalid(m_axil_wvalid),
    .m_axil_wready(m_axil_wready), .m_axil_bresp(m_axil_bresp), .m_axil_bvalid(m_axil_bvalid),
    .m_axil_bready(m_axil_bready), .s_axil_awaddr(s_axil_awaddr), .s_axil_awvalid(s_axil_awvalid),
    .s_axil_awready(s_axil_awready), .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb),
    .s_axil_wvalid(s_axil_wvalid), .s_axil_wready(s_axil_wready), .s_axil_bresp(s_axil_bresp),
    .s_axil_bvalid(s_axil_bvalid), .s_axil_bready(s_axil_bready)
  );

  // Decoder model: four 4 KiB windows at 0x0000..0x3FFF, registered one cycle after AW&W valid.
  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      slv_valid   <= '0;
      slv_invalid <= 1'b0;
    end else if (m_axil_awvalid && m_axil_wvalid) begin
      if (m_axil_awaddr < 32'h4000) begin
        slv_valid   <= 4'b0001 << m_axil_awaddr[13:12];
        slv_invalid <= 1'b0;
      end else begin
        slv_valid   <= '0;
        slv_invalid <= 1'b1;
      end
    end else begin
      slv_valid   <= '0;
      slv_invalid <= 1'b0;
    end
  end

  for (genvar g = 0; g < NS; g++) begin : g_slv
    assign s_axil_awready[g]      = s_axil_awvalid[g] && !got_aw[g] && (aw_cnt[g] >= aw_lat[g]);
    assign s_axil_wready[g]       = s_axil_wvalid[g] && !got_w[g] && (w_cnt[g] >= w_lat[g]);
    assign s_axil_bresp[2*g +: 2] = resp_cfg[g];
  end

  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < NS; i++) begin
        aw_cnt[i] <= 0; w_cnt[i] <= 0; got_aw[i] <= 1'b0; got_w[i] <= 1'b0;
        s_axil_bvalid[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < NS; i++) begin
        if (s_axil_awvalid[i] && s_axil_awready[i]) begin
          got_aw[i] <= 1'b1; aw_cnt[i] <= 0;
        end else if (s_axil_awvalid[i]) aw_cnt[i] <= aw_cnt[i] + 1;
        if (s_axil_wvalid[i] && s_axil_wready[i]) begin
          got_w[i] <= 1'b1; w_cnt[i] <= 0;
        end else if (s_axil_wvalid[i]) w_cnt[i] <= w_cnt[i] + 1;
        if (got_aw[i] && got_w[i] && !s_axil_bvalid[i]) begin
          s_axil_bvalid[i] <= 1'b1; got_aw[i] <= 1'b0; got_w[i] <= 1'b0;
        end
        if (s_axil_bvalid[i] && s_axil_bready[i]) s_axil_bvalid[i] <= 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: route checked on each master AW handshake, response on each master B handshake.
  always @(negedge aclk) begin
    if (aresetn) begin
      if (m_axil_awvalid && m_axil_awready) begin
        if (exp_route_q.size() == 0) chk("route_unexpected", 32'(s_axil_awvalid), 32'hFFFF_FFFF);
        else chk("route", 32'(s_axil_awvalid), 32'(exp_route_q.pop_front()));
      end
      if (m_axil_bvalid && m_axil_bready) begin
        if (exp_resp_q.size() == 0) chk("resp_unexpected", 32'(m_axil_bresp), 32'hFFFF_FFFF);
        else chk("bresp", 32'(m_axil_bresp), 32'(exp_resp_q.pop_front()));
      end
    end
  end

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input logic [3:0] mask, input logic [1:0] resp, input int hold,
                          input bit is_err, output int aw_cyc, output int w_cyc);
    int cyc, first, n, aw_p, w_p;
    bit aw_h, w_h;
    exp_route_q.push_back(mask);
    exp_resp_q.push_back(resp);
    @(posedge aclk); #1;
    m_axil_awaddr = addr; m_axil_wdata = data; m_axil_wstrb = strb;
    m_axil_awvalid = 1'b1; m_axil_wvalid = 1'b1;
    cyc = -1; first = -1; aw_cyc = -1; w_cyc = -1; aw_p = 0; w_p = 0;
    while ((m_axil_awvalid || m_axil_wvalid) && cyc < 40) begin
      @(negedge aclk); cyc++;
      if (first < 0 && ((|s_axil_awvalid) || m_axil_awready)) begin
        first = cyc;
        chk("bcast_addr", s_axil_awaddr, addr);
        chk("bcast_data", s_axil_wdata, data);
        chk("bcast_strb", 32'(s_axil_wstrb), 32'(strb));
      end
      if (is_err) chk("err_no_slave_valid", 32'(s_axil_awvalid | s_axil_wvalid), 32'h0);
      if (aw_cyc >= 0) chk("aw_dropped_after_hs", 32'(s_axil_awvalid), 32'h0);
      chk("no_early_bvalid", 32'(m_axil_bvalid), 32'h0);
      aw_h = m_axil_awvalid && m_axil_awready;
      w_h  = m_axil_wvalid && m_axil_wready;
      if (m_axil_awready) begin aw_p++; aw_cyc = cyc; end
      if (m_axil_wready)  begin w_p++;  w_cyc = cyc; end
      @(posedge aclk); #1;
      if (aw_h) m_axil_awvalid = 1'b0;
      if (w_h)  m_axil_wvalid  = 1'b0;
    end
    chk("hs_done", 32'({m_axil_awvalid, m_axil_wvalid}), 32'h0);
    m_axil_awvalid = 1'b0; m_axil_wvalid = 1'b0;
    chk("first_activity_cycle", 32'(first), 32'd2);
    chk("awready_pulses", 32'(aw_p), 32'd1);
    chk("wready_pulses", 32'(w_p), 32'd1);
    if (is_err) chk("err_aw_w_same_cycle", 32'(w_cyc), 32'(aw_cyc));
    n = 0;
    do begin
      @(negedge aclk); cyc++; n++;
    end while (!m_axil_bvalid && n < 40);
    chk("bvalid_seen", 32'(m_axil_bvalid), 32'h1);
    if (!m_axil_bvalid) return;
    if (is_err) chk("err_b_latency", 32'(cyc), 32'd3);
    for (int h = 0; h < hold; h++) begin
      if (h > 0) begin @(posedge aclk); #1; @(negedge aclk); end
      chk("b_hold_valid", 32'(m_axil_bvalid), 32'h1);
      chk("b_hold_resp", 32'(m_axil_bresp), 32'(resp));
      chk("b_hold_sbready", 32'(s_axil_bready), 32'h0);
    end
    @(posedge aclk); #1; m_axil_bready = 1'b1;
    @(negedge aclk);
    chk("sbready_routed", 32'(s_axil_bready), is_err ? 32'h0 : 32'(mask));
    @(posedge aclk); #1; m_axil_bready = 1'b0;
    @(negedge aclk);
    chk("b_cleared", 32'(m_axil_bvalid), 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int awc, wc, n;
    for (int i = 0; i < NS; i++) begin aw_lat[i] = 0; w_lat[i] = 0; resp_cfg[i] = 2'b00; end
    aresetn = 1'b0;
    m_axil_awaddr = 32'hA5A5_0000; m_axil_wdata = 32'h1234_5678; m_axil_wstrb = 4'h9;
    m_axil_awvalid = 1'b0; m_axil_wvalid = 1'b0; m_axil_bready = 1'b0;
    #12;
    chk("rst_outputs", 32'({m_axil_awready, m_axil_wready, m_axil_bvalid, m_axil_bresp,
                            s_axil_awvalid, s_axil_wvalid, s_axil_bready}), 32'h0);
    chk("rst_awaddr_pass", s_axil_awaddr, 32'hA5A5_0000);
    chk("rst_wdata_pass", s_axil_wdata, 32'h1234_5678);
    chk("rst_wstrb_pass", 32'(s_axil_wstrb), 32'h9);
    @(posedge aclk); #1; aresetn = 1'b1;

    // basic write to slave 1
    do_write(32'h1004, 32'hDEADBEEF, 4'hF, 4'b0010, 2'b00, 0, 1'b0, awc, wc);
    // unmapped: DECERR held 5 cycles
    do_write(32'h8000, 32'h0BAD_0BAD, 4'h3, 4'b0000, 2'b11, 5, 1'b1, awc, wc);
    // slave 2 takes AW 3 cycles before W
    w_lat[2] = 3;
    do_write(32'h2010, 32'hCAFE_F00D, 4'hC, 4'b0100, 2'b00, 0, 1'b0, awc, wc);
    chk("aw_before_w_gap", 32'(wc - awc), 32'd3);
    w_lat[2] = 0;
    // slave 3 SLVERR with master stall
    resp_cfg[3] = 2'b10;
    do_write(32'h3008, 32'h5555_AAAA, 4'h1, 4'b1000, 2'b10, 4, 1'b0, awc, wc);
    resp_cfg[3] = 2'b00;
    // back-to-back mixed routing
    do_write(32'h0040, 32'h0000_0001, 4'hF, 4'b0001, 2'b00, 0, 1'b0, awc, wc);
    do_write(32'h9000, 32'h0000_0002, 4'hF, 4'b0000, 2'b11, 0, 1'b1, awc, wc);
    do_write(32'h3FFC, 32'h0000_0003, 4'hF, 4'b1000, 2'b00, 0, 1'b0, awc, wc);

    // reset after AW handshake, before W handshake
    w_lat[1] = 10;
    exp_route_q.push_back(4'b0010);
    @(posedge aclk); #1;
    m_axil_awaddr = 32'h1100; m_axil_wdata = 32'h7777_7777; m_axil_wstrb = 4'hF;
    m_axil_awvalid = 1'b1; m_axil_wvalid = 1'b1;
    n = 0;
    do begin
      @(negedge aclk); n++;
    end while (!m_axil_awready && n < 20);
    chk("abort_aw_seen", 32'(m_axil_awready), 32'h1);
    @(posedge aclk); #1; m_axil_awvalid = 1'b0;
    #2;
    chk("pre_rst_wvalid", 32'(s_axil_wvalid), 32'b0010);
    aresetn = 1'b0;
    #1;
    chk("rst_async_outputs", 32'({m_axil_awready, m_axil_wready, m_axil_bvalid, m_axil_bresp,
                                  s_axil_awvalid, s_axil_wvalid, s_axil_bready}), 32'h0);
    m_axil_wvalid = 1'b0;
    w_lat[1] = 0;
    @(posedge aclk); #1; aresetn = 1'b1;
    @(negedge aclk);
    chk("abort_no_bvalid", 32'(m_axil_bvalid), 32'h0);
    do_write(32'h2000, 32'h1357_9BDF, 4'hF, 4'b0100, 2'b00, 0, 1'b0, awc, wc);

    repeat (3) @(posedge aclk);
    chk("route_q_drained", 32'(exp_route_q.size()), 32'h0);
    chk("resp_q_drained", 32'(exp_resp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
